// File: rtl/uart_encoder.sv
// uart_encoder
//
// Serial UART transmitter used to drive frames into the SoC receive pad.
// Bytes enter through a valid/ready handshake and wait in a small circular
// FIFO. They are then sent LSB first as start + 8 data + stop frame(s). The
// line idles high.
//
// Optional feature: define UART_ENCODER_PARITY_EN to insert an even parity
// bit between the data bits and the stop bit(s). The default build sends
// 8N1 frames.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte FIFO entries (power of 2, >= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   data_i        byte to send, written when valid_i && ready_o at an edge
//   valid_i       data_i is valid
//   ready_o       FIFO has room for another byte
//   uart_rx_o     registered serial line to the SoC receive pad, idle 1
//   busy_o        frame in progress or FIFO not empty
//   tx_done_o     one-cycle pulse in the final cycle of the last stop bit
//   fifo_level_o  current FIFO occupancy
module uart_encoder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          uart_rx_o,
    output logic                          busy_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_ENCODER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping. The pointers carry one extra wrap bit.
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr_q;
    logic [LW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    fifo_head;

    // Transmitter state
    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          line_q, line_d;
    logic          baud_last;
    logic          stop_last;
`ifdef UART_ENCODER_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign ready_o      = (level_q != LEVEL_FULL);
    assign push         = valid_i && ready_o;
    assign fifo_empty   = (level_q == '0);
    assign fifo_head    = fifo_mem[rd_ptr_q[AW-1:0]];
    assign fifo_level_o = level_q;

    assign baud_last    = (baud_q == BAUD_LAST);
    assign stop_last    = (stop_q == STOP_LAST);

    assign uart_rx_o    = line_q;
    assign busy_o       = (state_q != IDLE) || !fifo_empty;
    assign tx_done_o    = (state_q == STOP) && baud_last && stop_last;

    // FIFO pointers and level. The FSM only pops when the FIFO holds data,
    // and a push is refused whenever the registered level says full, so the
    // level never wraps. A simultaneous push and pop leaves the level alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + LW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // FIFO storage. Reset flushes the FIFO through the pointers, so the
    // memory itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Transmitter state register. The serial line is registered from the
    // next-state values, so it changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            line_q   <= 1'b1;
`ifdef UART_ENCODER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
`ifdef UART_ENCODER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic. Every state leaves or advances on a bit boundary,
    // and the baud counter wraps to 0 at that boundary. This gives a fresh
    // count on every state entry, including the STOP -> START hand-off used
    // for back-to-back frames.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_last ? '0 : baud_q + CW'(1);
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        line_d   = 1'b1;
`ifdef UART_ENCODER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    bit_d   = '0;
                    stop_d  = 1'b0;
`ifdef UART_ENCODER_PARITY_EN
                    parity_d = ^fifo_head;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_ENCODER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_ENCODER_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    if (stop_last) begin
                        stop_d = 1'b0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            bit_d   = '0;
`ifdef UART_ENCODER_PARITY_EN
                            parity_d = ^fifo_head;
`endif
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
`ifdef UART_ENCODER_PARITY_EN
            PARITY:  line_d = parity_d;
`endif
            default: line_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_encoder.sv
// tb_uart_encoder
//
// Self-checking bench for uart_encoder with CLKS_PER_BIT = 4, FIFO_DEPTH = 16
// and STOP_BITS = 1. It contains three checkers:
//   - A table of bytes whose frames are compared cycle by cycle.
//   - Hand-written sequences for back-to-back frames, a full FIFO and reset
//     in the middle of a frame.
//   - A random phase. It is checked against a frame-level model: a queue of
//     pending bytes plus a position counter inside the current frame.
// A line monitor decodes frames back into bytes so that the hand-written
// sequences can also check ordering.
module tb_uart_encoder;

    localparam int CPB       = 4;
    localparam int DEPTH     = 16;
    localparam int STOP_BITS = 1;
`ifdef UART_ENCODER_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_LEN = (9 + STOP_BITS + PAR_BITS) * CPB;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int IDLE_WAIT = 3000;

    logic          clk;
    logic          rst;
    logic [7:0]    data_i;
    logic          valid_i;
    logic          ready_o;
    logic          uart_rx_o;
    logic          busy_o;
    logic          tx_done_o;
    logic [LW-1:0] fifo_level_o;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    uart_encoder #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .uart_rx_o   (uart_rx_o),
        .busy_o      (busy_o),
        .tx_done_o   (tx_done_o),
        .fifo_level_o(fifo_level_o)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case something upstream stalls the clock-driven flow
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required finish before limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge and are sampled at the next rising edge
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        valid_i = v;
        data_i  = d;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy_o !== 1'b0 || uart_rx_o !== 1'b1) && n < IDLE_WAIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= IDLE_WAIT) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_timeout: busy=%0b line=%0b, required busy=0 line=1", busy_o, uart_rx_o);
        end
    endtask

    // Level of frame bit k: start 0, data LSB first, optional parity, stop 1s
    function automatic logic frameBit(input logic [7:0] b, input logic par, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR_BITS == 1 && k == 9) return par;
        return 1'b1;
    endfunction

    // Frame-level reference model. The transmitter is either idle or at
    // position mPos inside a frame of FRAME_LEN cycles. A new byte is taken
    // when it is idle or in the last cycle of a frame. A push is taken when
    // fewer than DEPTH bytes were pending before the edge.
    logic [7:0] mq[$];
    bit         mActive = 1'b0;
    int         mPos = 0;
    logic [7:0] mCur = 8'h00;
    bit         mCanPush;
    bit         mLast;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mActive = 1'b0;
            mPos    = 0;
        end else begin
            mCanPush = valid_i && (mq.size() < DEPTH);
            mLast    = mActive && (mPos == FRAME_LEN - 1);
            if (mq.size() != 0 && (!mActive || mLast)) begin
                mCur    = mq.pop_front();
                mActive = 1'b1;
                mPos    = 0;
            end else if (mLast) begin
                mActive = 1'b0;
                mPos    = 0;
            end else if (mActive) begin
                mPos++;
            end
            if (mCanPush) mq.push_back(data_i);
        end
    end

    // Compare every output with the model once per cycle
    initial forever begin
        @(negedge clk);
        if (checkEn) begin
            checkOutput("model_line", 32'(uart_rx_o),
                        32'(mActive ? frameBit(mCur, ^mCur, mPos / CPB) : 1'b1));
            checkOutput("model_done", 32'(tx_done_o),
                        32'(mActive && (mPos == FRAME_LEN - 1)));
            checkOutput("model_busy", 32'(busy_o), 32'(mActive || (mq.size() != 0)));
            checkOutput("model_level", 32'(fifo_level_o), 32'(mq.size()));
            checkOutput("model_ready", 32'(ready_o), 32'(mq.size() != DEPTH));
        end
    end

    // Line monitor. It decodes each frame from the falling start edge. A
    // frame cut short by reset is discarded.
    logic [7:0] rxBytes[$];
    logic [7:0] monByte;
    bit         monAbort;

    initial forever begin
        @(negedge clk);
        if (checkEn && uart_rx_o === 1'b0) begin
            monByte  = 8'h00;
            monAbort = 1'b0;
            for (int c = 1; c < FRAME_LEN; c++) begin
                @(negedge clk);
                if (rst) monAbort = 1'b1;
                if (c / CPB >= 1 && c / CPB <= 8 && c % CPB == CPB / 2)
                    monByte[c / CPB - 1] = uart_rx_o;
            end
            if (!monAbort) rxBytes.push_back(monByte);
        end
    end

    int burst;

    initial begin
        // Even parity of each byte, worked out by hand
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h07, 1'b1};
        vecs[4] = '{8'h03, 1'b0};
        vecs[5] = '{8'hA5, 1'b0};
        vecs[6] = '{8'h80, 1'b1};
        vecs[7] = '{8'h01, 1'b1};

        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        checkEn = 1'b1;

        $display("[TB] reset values");
        checkOutput("reset_line", 32'(uart_rx_o), 32'd1);
        checkOutput("reset_ready", 32'(ready_o), 32'd1);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_done", 32'(tx_done_o), 32'd0);
        checkOutput("reset_level", 32'(fifo_level_o), 32'd0);

        $display("[TB] single-frame table");
        for (int i = 0; i < 8; i++) begin
            waitIdle();
            applyStimulus(1'b1, vecs[i].data);
            applyStimulus(1'b0, 8'h00);
            checkOutput("latency_still_idle", 32'(uart_rx_o), 32'd1);
            checkOutput("level_after_push", 32'(fifo_level_o), 32'd1);
            for (int c = 0; c < FRAME_LEN; c++) begin
                @(negedge clk);
                checkOutput("frame_bit", 32'(uart_rx_o), 32'(frameBit(vecs[i].data, vecs[i].par, c / CPB)));
                checkOutput("frame_done", 32'(tx_done_o), 32'(c == FRAME_LEN - 1));
            end
            @(negedge clk);
            checkOutput("post_frame_line", 32'(uart_rx_o), 32'd1);
            checkOutput("post_frame_busy", 32'(busy_o), 32'd0);
        end

        // The second push lands on the same edge as the first pop, so the
        // level stays at 1 until the second frame starts.
        $display("[TB] back-to-back frames");
        waitIdle();
        rxBytes.delete();
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        checkOutput("b2b_level_first", 32'(fifo_level_o), 32'd1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("b2b_level_pushpop", 32'(fifo_level_o), 32'd1);
        checkOutput("b2b_start_line", 32'(uart_rx_o), 32'd0);
        repeat (FRAME_LEN - 1) @(negedge clk);
        checkOutput("b2b_done_first", 32'(tx_done_o), 32'd1);
        checkOutput("b2b_stop_line", 32'(uart_rx_o), 32'd1);
        @(negedge clk);
        checkOutput("b2b_no_gap_line", 32'(uart_rx_o), 32'd0);
        checkOutput("b2b_level_second", 32'(fifo_level_o), 32'd0);
        checkOutput("b2b_busy", 32'(busy_o), 32'd1);
        waitIdle();
        checkOutput("b2b_count", 32'(rxBytes.size()), 32'd2);
        if (rxBytes.size() == 2) begin
            checkOutput("b2b_byte0", 32'(rxBytes[0]), 32'h00);
            checkOutput("b2b_byte1", 32'(rxBytes[1]), 32'hFF);
        end

        // Fill the FIFO while 0xEE is on the line. 0x01..0x10 fit, and 0x11
        // is held valid up to and including the edge where 0xEE's frame ends
        // and the FIFO pops; it must be refused every time.
        $display("[TB] FIFO full");
        waitIdle();
        rxBytes.delete();
        applyStimulus(1'b1, 8'hEE);
        for (int k = 1; k <= 16; k++) applyStimulus(1'b1, 8'(k));
        for (int j = 0; j < FRAME_LEN - 15; j++) begin
            applyStimulus(1'b1, 8'h11);
            checkOutput("full_ready", 32'(ready_o), 32'd0);
            checkOutput("full_level", 32'(fifo_level_o), 32'd16);
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("full_level_after_pop", 32'(fifo_level_o), 32'd15);
        checkOutput("full_ready_after_pop", 32'(ready_o), 32'd1);
        waitIdle();
        checkOutput("full_count", 32'(rxBytes.size()), 32'd17);
        if (rxBytes.size() == 17) begin
            checkOutput("full_byte_first", 32'(rxBytes[0]), 32'hEE);
            for (int k = 1; k <= 16; k++) checkOutput("full_byte_order", 32'(rxBytes[k]), 32'(k));
        end

        // Reset during data bit 3 of 0xA5, with a second byte queued
        $display("[TB] reset mid-frame");
        waitIdle();
        rxBytes.delete();
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b0, 8'h00);
        repeat (4 * CPB + 1) @(negedge clk);
        checkOutput("rst_in_bit3", 32'(uart_rx_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_line", 32'(uart_rx_o), 32'd1);
        checkOutput("rst_level", 32'(fifo_level_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(tx_done_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME_LEN; c++) begin
            @(negedge clk);
            checkOutput("rst_no_done", 32'(tx_done_o), 32'd0);
            checkOutput("rst_line_idle", 32'(uart_rx_o), 32'd1);
        end
        checkOutput("rst_no_bytes", 32'(rxBytes.size()), 32'd0);

        // Random traffic with varying burst density and rare resets,
        // checked by the model process
        $display("[TB] random traffic");
        burst = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 200 == 0) burst = int'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 3) < burst) ? 1'b1 : 1'b0, 8'($urandom));
            rst = ($urandom_range(0, 799) == 0);
        end
        applyStimulus(1'b0, 8'h00);
        rst = 1'b0;
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
